hicore_clint: RTL

- Core-local interruptor: a 64-bit machine timer (mtime/mtimecmp) plus a software-interrupt register (msip).
- Drives the CPU's m_time_irq and m_soft_irq inputs, which are currently tied to 0 in the SoC top.
- Sits directly upstream of HiCore_cpu on the same clk/rst_n as the core.
- Registers are reached over a simple single-outstanding request/response bus from the core's data port.

---
 rtl/hicore_clint_pkg.sv | 18 +
 rtl/hicore_clint_timer.sv | 48 ++++
 rtl/hicore_clint.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/hicore_clint_pkg.sv
// hicore_clint shared definitions: register offsets,
// reset values and the bus FSM state type.
package hicore_clint_pkg;

  localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } clint_state_e;

endpackage

// File: rtl/hicore_clint_timer.sv
// hicore_clint machine timer: prescaler, 64-bit mtime
// and byte-wise write merge over the incremented value.
module hicore_clint_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtime_d_o
);

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic        tick;

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    // unwritten bytes keep the incremented value, carry included
    mtime_d = mtime_q + {63'd0, tick};
    for (int b = 0; b < 4; b++) begin
      if (wr_lo_i && wstrb_i[b])
        mtime_d[8*b +: 8] = wdata_i[8*b +: 8];
      if (wr_hi_i && wstrb_i[b])
        mtime_d[32+8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime_o   = mtime_q;
  assign mtime_d_o = mtime_d;

endmodule

// File: rtl/hicore_clint.sv
// hicore_clint: core-local interruptor with msip, mtimecmp
// and mtime behind a single-outstanding req/rsp bus.
module hicore_clint
  import hicore_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_req,
  output logic              bus_gnt,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  input  logic [3:0]        bus_wstrb,
  output logic              bus_rsp_valid,
  input  logic              bus_rsp_ready,
  output logic [31:0]       bus_rdata,
  output logic              bus_err,
  output logic              m_time_irq,
  output logic              m_soft_irq
);

  clint_state_e state_q, state_d;

  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        cmp_q, tirq_q, sirq_q;

  logic [63:0] mtime, mtime_nx;
  logic [ADDR_W-1:0] addr_w;
  logic [31:0] rmux;
  logic sel_msip, sel_cmp_lo, sel_cmp_hi;
  logic sel_mt_lo, sel_mt_hi, mapped;
  logic acc, wr;

  assign addr_w     = bus_addr & ~ADDR_W'(3);
  assign sel_msip   = addr_w == ADDR_W'(CLINT_MSIP_OFF);
  assign sel_cmp_lo = addr_w == ADDR_W'(CLINT_MTIMECMP_LO_OFF);
  assign sel_cmp_hi = addr_w == ADDR_W'(CLINT_MTIMECMP_HI_OFF);
  assign sel_mt_lo  = addr_w == ADDR_W'(CLINT_MTIME_LO_OFF);
  assign sel_mt_hi  = addr_w == ADDR_W'(CLINT_MTIME_HI_OFF);
  assign mapped     = sel_msip | sel_cmp_lo | sel_cmp_hi
                    | sel_mt_lo | sel_mt_hi;

  assign acc = bus_req && (state_q == IDLE);
  assign wr  = acc && bus_we;

  hicore_clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_lo_i   (wr && sel_mt_lo),
    .wr_hi_i   (wr && sel_mt_hi),
    .wdata_i   (bus_wdata),
    .wstrb_i   (bus_wstrb),
    .mtime_o   (mtime),
    .mtime_d_o (mtime_nx)
  );

  always_comb begin
    rmux = '0;
    unique case (1'b1)
      sel_msip:   rmux = {31'd0, msip_q};
      sel_cmp_lo: rmux = mtimecmp_q[31:0];
      sel_cmp_hi: rmux = mtimecmp_q[63:32];
      sel_mt_lo:  rmux = mtime[31:0];
      sel_mt_hi:  rmux = mtime[63:32];
      default:    rmux = '0;
    endcase
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    for (int b = 0; b < 4; b++) begin
      if (wr && sel_cmp_lo && bus_wstrb[b])
        mtimecmp_d[8*b +: 8] = bus_wdata[8*b +: 8];
      if (wr && sel_cmp_hi && bus_wstrb[b])
        mtimecmp_d[32+8*b +: 8] = bus_wdata[8*b +: 8];
    end
    if (wr && sel_msip && bus_wstrb[0])
      msip_d = bus_wdata[0];
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus_req) begin
          state_d = RESP;
          rdata_d = bus_we ? 32'd0 : rmux;
          err_d   = !mapped;
        end
      end
      RESP: begin
        if (bus_rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // compare looks ahead on mtime so a rise lands one cycle after
  // mtime reaches mtimecmp, while mtimecmp writes take two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mtimecmp_q <= CLINT_MTIMECMP_RST;
      msip_q     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cmp_q      <= 1'b0;
      tirq_q     <= 1'b0;
      sirq_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      cmp_q      <= (mtime_nx >= mtimecmp_q);
      tirq_q     <= cmp_q;
      sirq_q     <= msip_q;
    end
  end

  assign bus_gnt       = (state_q == IDLE);
  assign bus_rsp_valid = (state_q == RESP);
  assign bus_rdata     = rdata_q;
  assign bus_err       = err_q;
  assign m_time_irq    = tirq_q;
  assign m_soft_irq    = sirq_q;

endmodule
